// File: rtl/instr_word_encoder.sv
// Builds RV32I instruction words from decoded fields and streams them into
// instruction memory through a stalling write port, tracking fill level and errors.
module instr_word_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   words_written,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a request transfers on a rising edge where in_valid & in_ready;
  // a memory write transfers where mem_we & mem_ready, with mem_addr/mem_wdata
  // held stable from the first cycle mem_we is high until that transfer.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_CLASS = 2'b01;
  localparam logic [1:0] CODE_RANGE = 2'b10;
  localparam logic [1:0] CODE_ALIGN = 2'b11;

  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;

  logic [31:0] enc_word;
  logic [1:0]  enc_code;
  logic        illegal, misaligned, range_bad;
  logic        fits12, fits13, fits21, is_shift;
  logic        full_w, accept;

  // Immediate fits when all bits above the field width equal its sign bit.
  assign fits12   = (in_imm[31:11] == {21{in_imm[11]}});
  assign fits13   = (in_imm[31:12] == {20{in_imm[12]}});
  assign fits21   = (in_imm[31:20] == {12{in_imm[20]}});
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  always_comb begin
    enc_word   = 32'd0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    range_bad  = 1'b0;
    case (in_class)
      4'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      4'd1: begin
        if (is_shift) begin
          enc_word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IMM};
          range_bad = |in_imm[31:5];
        end else begin
          enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
          range_bad = ~fits12;
        end
      end
      4'd2: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        range_bad = ~fits12;
      end
      4'd3: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        range_bad = ~fits12;
      end
      4'd4: begin
        enc_word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], OP_BRANCH};
        misaligned = in_imm[0];
        range_bad  = ~fits13;
      end
      4'd5: begin
        enc_word   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        misaligned = in_imm[0];
        range_bad  = ~fits21;
      end
      4'd6: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
        range_bad = ~fits12;
      end
      4'd7: begin
        enc_word  = {in_imm[31:12], in_rd, OP_LUI};
        range_bad = |in_imm[11:0];
      end
      4'd8: begin
        enc_word  = {in_imm[31:12], in_rd, OP_AUIPC};
        range_bad = |in_imm[11:0];
      end
      default: illegal = 1'b1;
    endcase
    if (illegal)         enc_code = CODE_CLASS;
    else if (misaligned) enc_code = CODE_ALIGN;
    else if (range_bad)  enc_code = CODE_RANGE;
    else                 enc_code = CODE_NONE;
  end

  assign full_w   = (count_q == FULL_COUNT);
  assign in_ready = (state_q == S_IDLE) && !full_w && !start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_IDLE;
          addr_d  = BASE;
          count_d = '0;
          err_d   = 1'b0;
          code_d  = CODE_NONE;
        end else if (accept) begin
          if (enc_code != CODE_NONE) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = enc_code;
          end else begin
            state_d = S_WRITE;
            wdata_d = enc_word;
          end
        end
      end
      S_WRITE: begin
        // start is deliberately ignored here so the pending word always lands.
        if (mem_ready) begin
          state_d = S_IDLE;
          addr_d  = addr_q + 1'b1;
          count_d = full_w ? count_q : count_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      wdata_q <= 32'd0;
      count_q <= '0;
      err_q   <= 1'b0;
      code_q  <= CODE_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign mem_we        = (state_q == S_WRITE);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign words_written = count_q;
  assign full          = full_w;
  assign err           = err_q;
  assign err_code      = code_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Randomized bench for instr_word_encoder (4-word memory) checked against a
// field-placement reference model and a write scoreboard.
module tb_instr_word_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int W     = AW + 32;
  localparam int M_IDLE = 0, M_ERR = 2;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, mem_ready;
  logic          in_ready, mem_we, full, err, busy;
  logic [3:0]    in_class;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   words_written;
  logic [1:0]    err_code, dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  int       m_addr, m_count, m_state;
  logic     m_err;
  logic [1:0] m_code;

  instr_word_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .words_written(words_written), .full(full), .err(err), .err_code(err_code),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
    return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference model: instruction layout and legality from the RV32I rules.
  function automatic void ref_encode(input logic [3:0] cls, input logic [4:0] rd, rs1, rs2,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] imm,
                                     output logic [31:0] w, output logic [1:0] code);
    longint v = longint'($signed(imm));
    longint lo = 0, hi = 0;
    bit rng = 0, bad = 0;
    logic [31:0] r_d = 32'(rd) << 7, r_s1 = 32'(rs1) << 15, r_s2 = 32'(rs2) << 20;
    logic [31:0] f3s = 32'(f3) << 12;
    w = 32'd0;
    code = 2'b00;
    if (cls > 4'd8) begin
      code = 2'b01;
      return;
    end
    case (cls)
      4'd0: w = (32'(f7) << 25) | r_s2 | r_s1 | f3s | r_d | 32'h33;
      4'd1: begin
        rng = 1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          lo = 0; hi = 31;
          w = (32'(f7) << 25) | (fld(imm, 4, 0) << 20) | r_s1 | f3s | r_d | 32'h13;
        end else begin
          lo = -2048; hi = 2047;
          w = (fld(imm, 11, 0) << 20) | r_s1 | f3s | r_d | 32'h13;
        end
      end
      4'd2: begin
        rng = 1; lo = -2048; hi = 2047;
        w = (fld(imm, 11, 0) << 20) | r_s1 | f3s | r_d | 32'h03;
      end
      4'd3: begin
        rng = 1; lo = -2048; hi = 2047;
        w = (fld(imm, 11, 5) << 25) | r_s2 | r_s1 | f3s | (fld(imm, 4, 0) << 7) | 32'h23;
      end
      4'd4: begin
        rng = 1; lo = -4096; hi = 4094;
        w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | r_s2 | r_s1 | f3s |
            (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 32'h63;
      end
      4'd5: begin
        rng = 1; lo = -(64'sd1 << 20); hi = (64'sd1 << 20) - 2;
        w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20) |
            (fld(imm, 19, 12) << 12) | r_d | 32'h6F;
      end
      4'd6: begin
        rng = 1; lo = -2048; hi = 2047;
        w = (fld(imm, 11, 0) << 20) | r_s1 | r_d | 32'h67;
      end
      default: begin
        bad = (v % 4096) != 0;
        w = (imm & 32'hFFFF_F000) | r_d | ((cls == 4'd7) ? 32'h37 : 32'h17);
      end
    endcase
    if (rng && (v < lo || v > hi)) bad = 1;
    if ((cls == 4'd4 || cls == 4'd5) && (v % 2 != 0)) code = 2'b11;
    else if (bad) code = 2'b10;
  endfunction

  // Scoreboard: every committed write must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[W-1:32]));
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic check_idle_state(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(m_addr));
    chk({tag, "_count"}, 32'(words_written), 32'(m_count));
    chk({tag, "_full"}, 32'(full), 32'(m_count == DEPTH));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_code"}, 32'(err_code), 32'(m_code));
    chk({tag, "_busy"}, 32'(busy), 32'(m_state != M_IDLE));
    chk({tag, "_ready"}, 32'(in_ready), 32'(m_state == M_IDLE && m_count < DEPTH));
  endtask

  task automatic model_clear();
    m_addr = 0; m_count = 0; m_state = M_IDLE; m_err = 0; m_code = 2'b00;
  endtask

  // Driver: starts and ends just after a rising edge.
  task automatic send(input logic [3:0] cls, input logic [4:0] rd, rs1, rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                      input int stall, input bit start_in_write, input logic [32:0] fixed);
    logic [31:0] w;
    logic [1:0] code;
    bit exp_rdy;
    exp_rdy = (m_state == M_IDLE) && (m_count < DEPTH);
    in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!exp_rdy) return;
    ref_encode(cls, rd, rs1, rs2, f3, f7, imm, w, code);
    if (fixed[32]) w = fixed[31:0];
    if (code != 2'b00) begin
      m_err = 1; m_code = code; m_state = M_ERR;
      @(negedge clk);
      check_idle_state("err");
      @(posedge clk); #1;
      return;
    end
    exp_q.push_back({AW'(m_addr), w});
    if (stall > 0) begin
      mem_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        start = start_in_write && (i == 0);
        @(negedge clk);
        chk("stall_we", 32'(mem_we), 32'd1);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_ready", 32'(in_ready), 32'd0);
        chk("stall_addr", 32'(mem_addr), 32'(m_addr));
        chk("stall_data", mem_wdata, w);
        @(posedge clk); #1;
        start = 1'b0;
      end
      mem_ready = 1'b1;
    end
    @(negedge clk);
    chk("commit_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    m_addr = (m_addr + 1) % DEPTH;
    if (m_count < DEPTH) m_count++;
    @(negedge clk);
    check_idle_state("post");
    @(posedge clk); #1;
  endtask

  task automatic do_start(input bit with_valid);
    in_valid = with_valid;
    start = 1'b1;
    @(negedge clk);
    chk("start_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    check_idle_state("start");
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 9))
      0: return 32'($urandom_range(0, 31));
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return 32'($urandom_range(0, 4)) + 32'd2045;
      3: return 32'hFFFF_F7FE + 32'($urandom_range(0, 4));
      4: return 32'($urandom_range(0, 4)) + 32'd4093;
      5: return 32'hFFFF_EFFE + 32'($urandom_range(0, 4));
      6: return 32'h000F_FFFD + 32'($urandom_range(0, 4));
      7: return 32'hFFEF_FFFE + 32'($urandom_range(0, 4));
      8: return $urandom() & 32'hFFFF_F000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_state("reset");
    chk("reset_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;

    // Directed program: fills the 4-word memory.
    send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0, 0, 33'h1_0050_0093);
    send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0, 0, 33'h1_0020_81B3);
    send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8, 0, 0, 33'h1_FE20_8CE3);
    send(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 3, 1, 33'h1_1234_52B7);
    chk("full_flag", 32'(full), 32'd1);
    send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 0, 33'h0);
    do_start(1'b1);
    send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 0, 33'h1_0010_00EF);

    // Error paths.
    send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 0, 33'h0);
    chk("err_range", 32'(err_code), 32'd2);
    send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 0, 0, 33'h0);
    do_start(1'b0);
    send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 0, 0, 33'h0);
    chk("err_align", 32'(err_code), 32'd3);
    do_start(1'b0);
    send(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0, 0, 33'h0);
    chk("err_class", 32'(err_code), 32'd1);
    do_start(1'b0);

    // Reset in the middle of a stalled write.
    in_class = 4'd1; in_rd = 5'd2; in_rs1 = 5'd0; in_funct3 = 3'd0; in_imm = 32'd7;
    in_valid = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstw_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mem_ready = 1'b1;
    model_clear();
    @(negedge clk);
    check_idle_state("rstw");
    chk("rstw_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      logic [3:0] cls;
      if ((m_state == M_ERR || m_count == DEPTH) && $urandom_range(0, 3) != 0) do_start(1'b0);
      else if ($urandom_range(0, 15) == 0) do_start($urandom_range(0, 1) == 1);
      cls = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      send(cls, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
           rand_imm(), $urandom_range(0, 2), $urandom_range(0, 3) == 0, 33'h0);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_word_encoder.md
# instr_word_encoder

Assembles RV32I instruction words from decoded fields (class, registers, funct codes, immediate) and writes them sequentially into instruction memory through a stalling write port. It is the encode-side counterpart of the processor's opcode decoder and is used by the program loader and test infrastructure to build programs in hardware. It range-checks immediates, flags illegal requests, and tracks the fill level of the target memory.

## Interface
- ADDR_W, 10, word-address width of instruction memory
- BASE_ADDR, 0, first word address written after reset or `start`
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  restart: address to BASE_ADDR, count and error cleared
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_class  in  4  0=R 1=I-ALU 2=LOAD 3=STORE 4=BRANCH 5=JAL 6=JALR 7=LUI 8=AUIPC; 9–15 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3;  in_funct7  in  7
- in_imm  in  32  signed immediate (byte offset for BRANCH/JAL, full value for LUI/AUIPC)
- mem_we  out  1  write request;  mem_ready  in  1  memory accepts when mem_we & mem_ready
- mem_addr  out  ADDR_W;  mem_wdata  out  32
- words_written  out  ADDR_W+1  words committed since reset/start
- full  out  1  words_written == 2^ADDR_W
- err  out  1  sticky error;  err_code  out  2  01 illegal class, 10 imm out of range, 11 misaligned offset
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, WRITE, ERR.
- in_ready = (state==IDLE) & ~full & ~start.
- Accept in IDLE: encode combinationally and register the word; no error → WRITE; error → ERR. err_code is set; no write occurs and the address is unchanged.
- Encoding (standard RV32I fields):
  - R: funct7|rs2|rs1|funct3|rd|0110011.
  - I-ALU (0010011) / LOAD (0000011) / JALR (1100111): imm[11:0]|rs1|funct3|rd|op; range −2048..2047.
    - JALR forces funct3=000.
    - I-ALU with funct3 001/101: bits[31:25]=funct7, bits[24:20]=imm[4:0], range 0..31.
  - STORE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011; range −2048..2047.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011; range −4096..4094; imm[0] must be 0.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111; range −2^20..2^20−2; imm[0] must be 0.
  - LUI (0110111) / AUIPC (0010111): imm[31:12]|rd|op; imm[11:0] must be 0, else code 10.
- Error priority: illegal class > misaligned > out of range.
- WRITE: mem_we=1; mem_addr and mem_wdata held stable until mem_ready.
  - On handshake: mem_addr+1 (wraps modulo 2^ADDR_W), words_written+1, → IDLE.
- ERR: in_ready=0 until `start` or rst.
- start in IDLE or ERR: next cycle IDLE, mem_addr=BASE_ADDR, words_written=0, err=0, err_code=00. start in WRITE is ignored; the pending write completes.
- full: in_ready=0 until start; words_written saturates at 2^ADDR_W.

## Timing
- Reset values: state IDLE, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, words_written 0, full 0, err 0, err_code 00, busy 0, in_ready 1.
- Accept at edge N → mem_we=1 in cycle N+1. With mem_ready=1, commit at edge N+1 and in_ready=1 in cycle N+2. Peak throughput is 1 word per 2 cycles.
- Error accept at edge N → err=1 in cycle N+1; mem_we stays 0.
- rst mid-WRITE aborts the write: mem_we=0 the next cycle and the counters are zeroed.
- start and in_valid in the same cycle: start wins and the request is not accepted.

## Test plan
- addi x1,x0,5 (class 1, rd 1, rs1 0, f3 0, imm 5) → mem_wdata 0x00500093 at addr 0; words_written 1.
- add x3,x1,x2 (class 0, f7 0) then beq x1,x2,−8 (class 4) → 0x002081B3 at addr 1, then 0xFE208CE3 at addr 2.
- lui x5,0x12345000 → 0x123452B7; jal x1,+2048 → 0x001000EF.
- addi imm=2048 → err=1, code 10, no mem_we, in_ready=0. Then beq imm=3 after start → code 11. Class 12 → code 01. start clears err.
- mem_ready low 3 cycles in WRITE → mem_we, addr, data stable; busy=1; in_ready=0. Commit on the 4th cycle.
- ADDR_W=2: 4 writes → full=1, mem_addr wraps to 0, in_ready=0. start → words_written 0, accepting again. rst mid-WRITE → no commit, all outputs at reset values.
